// File: rtl/sdm_cic_decimator.sv
// rtl/sdm_cic_decimator.sv - ORDER-stage CIC decimator recovering PCM from a 1-bit SDM stream
// Integrators use the cascaded new-value form (int(k) adds the freshly updated int(k-1)).
// Optional SDM_CIC_SYNC_EN adds sync_in, which restarts the frame and flushes the filter.
module sdm_cic_decimator #(
   parameter int ORDER = 2,
   parameter int LOG2R = 6,
   localparam int OW = ORDER * LOG2R + 2
) (
   input  logic          clk,
   input  logic          rst,
`ifdef SDM_CIC_SYNC_EN
   input  logic          sync_in,
`endif
   input  logic          in_bit,
   input  logic          in_valid,
   output logic [OW-1:0] out_data,
   output logic          out_valid,
   output logic          settled
);

   localparam logic [1:0] ORDER_L = 2'(ORDER);

   logic          sync_w;
   logic [OW-1:0] mapped;
   logic [OW-1:0] acc;
   logic [OW-1:0] comb_c [ORDER+1];

   logic [OW-1:0]    integ_q [ORDER];
   logic [OW-1:0]    integ_d [ORDER];
   logic [OW-1:0]    dly_q   [ORDER];
   logic [OW-1:0]    dly_d   [ORDER];
   logic [OW-1:0]    cap_q, cap_d;
   logic [LOG2R-1:0] phase_q, phase_d;
   logic             dec_q, dec_d;
   logic [OW-1:0]    out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       settle_cnt_q, settle_cnt_d;
   logic [1:0]       settle_inc;
   logic             settled_q, settled_d;

`ifdef SDM_CIC_SYNC_EN
   assign sync_w = sync_in;
`else
   assign sync_w = 1'b0;
`endif

   assign mapped = in_bit ? OW'(1) : {OW{1'b1}};

   always_comb begin
      integ_d      = integ_q;
      dly_d        = dly_q;
      cap_d        = cap_q;
      phase_d      = phase_q;
      dec_d        = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      settle_cnt_d = settle_cnt_q;
      settled_d    = settled_q;
      settle_inc   = settle_cnt_q + 2'd1;
      acc          = mapped;

      // Combs run one edge after decimation on the captured last-stage integrator.
      comb_c[0] = cap_q;
      for (int k = 1; k <= ORDER; k++) begin
         comb_c[k] = comb_c[k-1] - dly_q[k-1];
      end

      if (dec_q && !sync_w) begin
         for (int k = 0; k < ORDER; k++) begin
            dly_d[k] = comb_c[k];
         end
         out_data_d  = comb_c[ORDER];
         out_valid_d = 1'b1;
         if (settle_cnt_q != ORDER_L) begin
            settle_cnt_d = settle_inc;
         end
         if (settle_inc == ORDER_L) begin
            settled_d = 1'b1;
         end
      end

      if (sync_w) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = '0;
            dly_d[k]   = '0;
         end
         phase_d      = '0;
         settle_cnt_d = '0;
         settled_d    = 1'b0;
      end

      // integ_d/phase_d already hold either the running or the freshly cleared base.
      if (in_valid) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_d[k] + acc;
            acc        = integ_d[k];
         end
         phase_d = phase_d + LOG2R'(1);
         dec_d   = (&phase_q) && !sync_w;
         if (dec_d) begin
            cap_d = integ_d[ORDER-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
         cap_q        <= '0;
         phase_q      <= '0;
         dec_q        <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         settle_cnt_q <= '0;
         settled_q    <= 1'b0;
      end else begin
         integ_q      <= integ_d;
         dly_q        <= dly_d;
         cap_q        <= cap_d;
         phase_q      <= phase_d;
         dec_q        <= dec_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         settle_cnt_q <= settle_cnt_d;
         settled_q    <= settled_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign settled   = settled_q;

endmodule

// File: tb/tb_sdm_cic_decimator.sv
// tb/tb_sdm_cic_decimator.sv - bench for sdm_cic_decimator (defaults ORDER=2, LOG2R=6)
`timescale 1ns/1ps
module tb_sdm_cic_decimator;

   localparam int OW = 14;
   localparam int R  = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_bit = 1'b0;
   logic          in_valid = 1'b0;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          settled;
`ifdef SDM_CIC_SYNC_EN
   logic          sync_in = 1'b0;
`endif

   sdm_cic_decimator dut (
      .clk(clk),
      .rst(rst),
`ifdef SDM_CIC_SYNC_EN
      .sync_in(sync_in),
`endif
      .in_bit(in_bit),
      .in_valid(in_valid),
      .out_data(out_data),
      .out_valid(out_valid),
      .settled(settled)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int data;
      int settled;
      int cyc;
      int gap;
   } exp_t;

   typedef struct {
      int pattern;   // 0 ones, 1 zeros, 2 alt starting 1, 3 alt starting 0
      int vper;      // 0 = random gaps, else one valid bit every vper clocks
      int frames;
      int e0;
      int e1;
      int er;
   } vec_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_bad = 0;
   int acc_cnt = 0;
   int frame = 0;
   int prev_cyc = 0;
   int last_out = 0;
   int cur_e0, cur_e1, cur_er, cur_gap;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (rst) return;
      if (out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("out_data", int'($signed(out_data)), e.data);
            chk("settled", int'(settled), e.settled);
            chk("latency_cycle", cyc, e.cyc);
            if (e.gap != 0) chk("out_valid_period", cyc - prev_cyc, e.gap);
         end
         prev_cyc = cyc;
         last_out = int'($signed(out_data));
      end else begin
         chk("out_data_hold", int'($signed(out_data)), last_out);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
   endtask

   task automatic note_accept();
      exp_t e;
      acc_cnt++;
      if (acc_cnt % R == 0) begin
         frame++;
         e.data    = (frame == 1) ? cur_e0 : (frame == 2) ? cur_e1 : cur_er;
         e.settled = (frame >= 2) ? 1 : 0;
         e.cyc     = cyc + 2;
         e.gap     = (frame > 1) ? cur_gap : 0;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic b, input logic v);
      tick();
      in_bit   = b;
      in_valid = v;
`ifdef SDM_CIC_SYNC_EN
      sync_in  = 1'b0;
`endif
      if (v) note_accept();
   endtask

   task automatic do_reset();
      tick();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_settled", int'(settled), 0);
      rst      = 1'b0;
      acc_cnt  = 0;
      frame    = 0;
      last_out = 0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      tick();
      in_valid = 1'b0;
      while (sb.size() != 0 && t < 400) begin
         tick();
         t++;
      end
      chk("drain_pending", sb.size(), 0);
      sb.delete();
   endtask

   function automatic logic pat_bit(input int pattern, input int i);
      case (pattern)
         0: return 1'b1;
         1: return 1'b0;
         2: return (i % 2 == 0);
         default: return (i % 2 == 1);
      endcase
   endfunction

   vec_t vecs[6];

   initial begin
      vecs[0] = '{pattern: 0, vper: 1, frames: 4, e0: 2080,  e1: 4096,  er: 4096};
      vecs[1] = '{pattern: 1, vper: 1, frames: 4, e0: -2080, e1: -4096, er: -4096};
      vecs[2] = '{pattern: 2, vper: 1, frames: 4, e0: 32,    e1: 0,     er: 0};
      vecs[3] = '{pattern: 3, vper: 1, frames: 3, e0: -32,   e1: 0,     er: 0};
      vecs[4] = '{pattern: 0, vper: 3, frames: 3, e0: 2080,  e1: 4096,  er: 4096};
      vecs[5] = '{pattern: 0, vper: 0, frames: 3, e0: 2080,  e1: 4096,  er: 4096};

      for (int v = 0; v < 6; v++) begin
         do_reset();
         cur_e0  = vecs[v].e0;
         cur_e1  = vecs[v].e1;
         cur_er  = vecs[v].er;
         cur_gap = vecs[v].vper * R;
         for (int i = 0; i < vecs[v].frames * R; i++) begin
            if (vecs[v].vper == 0) begin
               repeat ($urandom_range(0, 2)) send(pat_bit(vecs[v].pattern, i), 1'b0);
            end else begin
               repeat (vecs[v].vper - 1) send(pat_bit(vecs[v].pattern, i), 1'b0);
            end
            send(pat_bit(vecs[v].pattern, i), 1'b1);
         end
         drain();
      end

      // Mid-frame reset: frame 3 is abandoned after 40 bits, next frame restarts cleanly.
      do_reset();
      cur_e0 = 2080; cur_e1 = 4096; cur_er = 4096; cur_gap = R;
      for (int i = 0; i < 2 * R + 40; i++) send(1'b1, 1'b1);
      chk("pre_rst_settled", int'(settled), 1);
      do_reset();
      for (int i = 0; i < 2 * R; i++) send(1'b1, 1'b1);
      drain();

`ifdef SDM_CIC_SYNC_EN
      do_reset();
      cur_e0 = 2080; cur_e1 = 4096; cur_er = 4096; cur_gap = R;
      for (int i = 0; i < 2 * R + 22; i++) send(1'b1, 1'b1);
      tick();
      in_bit   = 1'b1;
      in_valid = 1'b1;
      sync_in  = 1'b1;
      acc_cnt  = 0;
      frame    = 0;
      note_accept();
      tick();
      sync_in  = 1'b0;
      note_accept();
      chk("sync_settled", int'(settled), 0);
      chk("sync_out_valid", int'(out_valid), 0);
      chk("sync_out_data_hold", int'($signed(out_data)), 4096);
      for (int i = 0; i < R - 2; i++) send(1'b1, 1'b1);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
